// File: rtl/flash_to_sram_copier.sv
// ---------------------------------------------------------------------------
// flash_to_sram_copier
//
// Bulk copy engine that moves a byte range from parallel flash into SRAM
// (for example, loading gamma/calibration tables at boot). It talks to the
// external memory controller through its flash-read and SRAM-write req/idle
// ports and copies one byte at a time: a flash read, then an SRAM write.
// It reports progress, a 16-bit additive checksum of the copied data and a
// handshake-timeout error.
//
// Ports
//   CLK_40              system clock, 40 MHz
//   reset               asynchronous, active-high
//   start               1-cycle pulse, begins a copy using src/dst/length
//   abort               1-cycle pulse, stops after the byte in flight
//   src_addr[19:0]      first flash byte address
//   dst_addr[17:0]      first SRAM byte address
//   length[17:0]        number of bytes to copy, 0 = no-op
//   busy                high while a copy is running
//   done                1-cycle pulse on completion, abort or error
//   error               sticky handshake timeout flag
//   aborted             sticky, last run was ended by abort
//   bytes_copied[17:0]  bytes written to SRAM in current/last run
//   checksum[15:0]      sum mod 2^16 of bytes written in current/last run
//   flash_read_*        flash read handshake to/from the controller
//   sram_write_*        SRAM write handshake to/from the controller
// ---------------------------------------------------------------------------
module flash_to_sram_copier #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK_40,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [19:0] src_addr,
    input  logic [17:0] dst_addr,
    input  logic [17:0] length,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        aborted,
    output logic [17:0] bytes_copied,
    output logic [15:0] checksum,
    output logic        flash_read_req,
    output logic [19:0] flash_read_address,
    input  logic [7:0]  flash_read_data,
    input  logic        flash_read_idle,
    output logic        sram_write_req,
    output logic [17:0] sram_write_address,
    output logic [7:0]  sram_write_data,
    input  logic        sram_write_idle
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FR_ACK,
        ST_FR_DONE,
        ST_SW_ACK,
        ST_SW_DONE,
        ST_NEXT,
        ST_FINISH
    } state_t;

    // A phase times out on its TIMEOUT_CYCLES-th cycle without progress.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;

    logic [19:0] cur_src;
    logic [17:0] cur_dst;
    logic [17:0] remaining;
    logic [7:0]  data_latch;
    logic [15:0] phase_cnt;
    logic        abort_pending;

    logic        go_run;
    logic        go_noop;
    logic        read_done;
    logic        write_done;
    logic        timeout_hit;
    logic        phase_expired;

    assign phase_expired      = (phase_cnt >= TIMEOUT_LAST);
    assign flash_read_address = cur_src;
    assign sram_write_address = cur_dst;
    assign sram_write_data    = data_latch;

    // State register. Requests are decoded from state, so reset drops them
    // without waiting for a clock edge.
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and request decode. Progress on a handshake wins over a
    // timeout that expires in the same cycle.
    always_comb begin
        state_next     = state;
        flash_read_req = 1'b0;
        sram_write_req = 1'b0;
        go_run         = 1'b0;
        go_noop        = 1'b0;
        read_done      = 1'b0;
        write_done     = 1'b0;
        timeout_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                // A start that coincides with abort is dropped entirely.
                if (start && !abort) begin
                    if (length != 18'd0) begin
                        go_run     = 1'b1;
                        state_next = ST_FR_ACK;
                    end else begin
                        go_noop    = 1'b1;
                    end
                end
            end
            ST_FR_ACK: begin
                flash_read_req = 1'b1;
                if (!flash_read_idle) begin
                    state_next = ST_FR_DONE;
                end else if (phase_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_FINISH;
                end
            end
            ST_FR_DONE: begin
                flash_read_req = 1'b1;
                if (flash_read_idle) begin
                    read_done  = 1'b1;
                    state_next = ST_SW_ACK;
                end else if (phase_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_FINISH;
                end
            end
            ST_SW_ACK: begin
                sram_write_req = 1'b1;
                if (!sram_write_idle) begin
                    state_next = ST_SW_DONE;
                end else if (phase_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_FINISH;
                end
            end
            ST_SW_DONE: begin
                sram_write_req = 1'b1;
                if (sram_write_idle) begin
                    write_done = 1'b1;
                    state_next = ST_NEXT;
                end else if (phase_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_FINISH;
                end
            end
            ST_NEXT: begin
                // Abort is only honoured here so a controller operation is
                // never cut off halfway.
                if ((remaining == 18'd0) || abort_pending) begin
                    state_next = ST_FINISH;
                end else begin
                    state_next = ST_FR_ACK;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: addresses, counters, checksum, status flags.
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            cur_src       <= 20'd0;
            cur_dst       <= 18'd0;
            remaining     <= 18'd0;
            data_latch    <= 8'd0;
            phase_cnt     <= 16'd0;
            abort_pending <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            aborted       <= 1'b0;
            bytes_copied  <= 18'd0;
            checksum      <= 16'd0;
        end else begin
            done <= 1'b0;

            // The phase counter measures time spent in the current state.
            if ((state_next != state) || (state == ST_IDLE)) begin
                phase_cnt <= 16'd0;
            end else begin
                phase_cnt <= phase_cnt + 16'd1;
            end

            if (abort && (state != ST_IDLE)) begin
                abort_pending <= 1'b1;
            end

            if (go_run) begin
                cur_src       <= src_addr;
                cur_dst       <= dst_addr;
                remaining     <= length;
                error         <= 1'b0;
                aborted       <= 1'b0;
                bytes_copied  <= 18'd0;
                checksum      <= 16'd0;
                abort_pending <= 1'b0;
                busy          <= 1'b1;
            end

            if (go_noop) begin
                error   <= 1'b0;
                aborted <= 1'b0;
                done    <= 1'b1;
            end

            if (read_done) begin
                data_latch <= flash_read_data;
            end

            if (write_done) begin
                bytes_copied <= bytes_copied + 18'd1;
                checksum     <= checksum + {8'd0, data_latch};
                cur_src      <= cur_src + 20'd1;
                cur_dst      <= cur_dst + 18'd1;
                remaining    <= remaining - 18'd1;
            end

            if (timeout_hit) begin
                error <= 1'b1;
            end

            if (state == ST_FINISH) begin
                busy          <= 1'b0;
                done          <= 1'b1;
                aborted       <= abort_pending;
                abort_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flash_to_sram_copier.sv
// ---------------------------------------------------------------------------
// tb_flash_to_sram_copier
//
// Self-checking bench for flash_to_sram_copier. Behavioural flash and SRAM
// controller responders with random handshake latency record every read and
// write; a reference model computes the expected address sequences, data,
// byte count, checksum and flags of each run from the copy rules directly.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_flash_to_sram_copier;

    localparam int TIMEOUT = 16;

    logic        CLK_40 = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [19:0] src_addr;
    logic [17:0] dst_addr;
    logic [17:0] length;
    logic        busy;
    logic        done;
    logic        error;
    logic        aborted;
    logic [17:0] bytes_copied;
    logic [15:0] checksum;
    logic        flash_read_req;
    logic [19:0] flash_read_address;
    logic [7:0]  flash_read_data;
    logic        flash_read_idle;
    logic        sram_write_req;
    logic [17:0] sram_write_address;
    logic [7:0]  sram_write_data;
    logic        sram_write_idle;

    int          num_checks = 0;
    int          num_errors = 0;
    int          both_req_cnt = 0;
    bit          hang_flash = 1'b0;
    int          abort_at = 0;
    int          rd_q[$];
    int          wr_addr_q[$];
    int          wr_data_q[$];
    bit [7:0]    flash_over[int];
    int          f_addr;
    int          s_addr;
    int          s_data;
    int          done_cnt;
    bit          wait_expired;

    flash_to_sram_copier #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLK_40             (CLK_40),
        .reset              (reset),
        .start              (start),
        .abort              (abort),
        .src_addr           (src_addr),
        .dst_addr           (dst_addr),
        .length             (length),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .aborted            (aborted),
        .bytes_copied       (bytes_copied),
        .checksum           (checksum),
        .flash_read_req     (flash_read_req),
        .flash_read_address (flash_read_address),
        .flash_read_data    (flash_read_data),
        .flash_read_idle    (flash_read_idle),
        .sram_write_req     (sram_write_req),
        .sram_write_address (sram_write_address),
        .sram_write_data    (sram_write_data),
        .sram_write_idle    (sram_write_idle)
    );

    always #12.5 CLK_40 = ~CLK_40;

    always @(posedge CLK_40) begin
        if (flash_read_req && sram_write_req) both_req_cnt <= both_req_cnt + 1;
    end

    // Flash contents: a fixed scramble of the address unless overridden.
    function automatic logic [7:0] flash_byte(input int a);
        if (flash_over.exists(a)) return flash_over[a];
        return 8'((a * 157) ^ (a >> 5) ^ 8'h3c);
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Flash read responder: drop idle after 0-2 cycles, raise it with data
    // 1-3 cycles later.
    initial begin
        flash_read_idle = 1'b1;
        flash_read_data = 8'd0;
        forever begin
            @(negedge CLK_40);
            if (flash_read_req && flash_read_idle && !hang_flash && !reset) begin
                f_addr = int'(flash_read_address);
                rd_q.push_back(f_addr);
                repeat ($urandom_range(0, 2)) @(negedge CLK_40);
                flash_read_idle = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge CLK_40);
                flash_read_data = flash_byte(f_addr);
                flash_read_idle = 1'b1;
            end
        end
    end

    // SRAM write responder; also fires abort while the copier waits for the
    // completion of the selected write.
    initial begin
        sram_write_idle = 1'b1;
        abort = 1'b0;
        forever begin
            @(negedge CLK_40);
            if (sram_write_req && sram_write_idle && !reset) begin
                s_addr = int'(sram_write_address);
                s_data = int'(sram_write_data);
                repeat ($urandom_range(0, 2)) @(negedge CLK_40);
                sram_write_idle = 1'b0;
                @(negedge CLK_40);
                if (abort_at != 0 && wr_addr_q.size() + 1 == abort_at) abort = 1'b1;
                @(negedge CLK_40);
                abort = 1'b0;
                repeat ($urandom_range(0, 1)) @(negedge CLK_40);
                wr_addr_q.push_back(s_addr);
                wr_data_q.push_back(s_data);
                sram_write_idle = 1'b1;
            end
        end
    end

    // Launch one copy and wait (bounded) for its done pulse. Optionally
    // fires a second start with different parameters while busy.
    task automatic applyStimulus(input logic [19:0] s, input logic [17:0] d,
                                 input logic [17:0] n, input int ab_at, input bit extra_start);
        rd_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        abort_at = ab_at;
        @(negedge CLK_40);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        @(negedge CLK_40);
        start = 1'b0;
        checkOutput("busy_after_start", busy, (n != 0));
        wait_expired = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (extra_start && c == 4) begin
                src_addr = 20'h12345;
                dst_addr = 18'h00777;
                length   = 18'd2;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                wait_expired = 1'b0;
                break;
            end
            @(negedge CLK_40);
        end
        start = 1'b0;
        checkOutput("done_wait", wait_expired, 0);
        if (!wait_expired) done_cnt = 1;
        repeat (3) begin
            @(negedge CLK_40);
            if (done) done_cnt++;
        end
        checkOutput("done_pulses", done_cnt, 1);
    endtask

    // Reference model: expected result of copying n bytes, cut short at
    // byte ab_at when an abort was fired.
    task automatic checkRun(input logic [19:0] s, input logic [17:0] d,
                            input logic [17:0] n, input int ab_at);
        int nexp;
        int sum;
        int fa;
        nexp = (ab_at != 0 && ab_at < int'(n)) ? ab_at : int'(n);
        sum = 0;
        for (int i = 0; i < nexp; i++) sum += flash_byte((int'(s) + i) & 32'hFFFFF);
        checkOutput("bytes_copied", bytes_copied, nexp);
        checkOutput("checksum", checksum, sum & 32'hFFFF);
        checkOutput("error", error, 0);
        checkOutput("aborted", aborted, (ab_at != 0));
        checkOutput("busy_end", busy, 0);
        checkOutput("reads", rd_q.size(), nexp);
        checkOutput("writes", wr_addr_q.size(), nexp);
        for (int i = 0; i < nexp && i < rd_q.size(); i++) begin
            checkOutput("rd_addr", rd_q[i], (int'(s) + i) & 32'hFFFFF);
        end
        for (int i = 0; i < nexp && i < wr_addr_q.size(); i++) begin
            fa = (int'(s) + i) & 32'hFFFFF;
            checkOutput("wr_addr", wr_addr_q[i], (int'(d) + i) & 32'h3FFFF);
            checkOutput("wr_data", wr_data_q[i], flash_byte(fa));
        end
    endtask

    task automatic runAndCheck(input logic [19:0] s, input logic [17:0] d,
                               input logic [17:0] n, input int ab_at, input bit extra_start);
        applyStimulus(s, d, n, ab_at, extra_start);
        checkRun(s, d, n, ab_at);
    endtask

    function automatic logic [127:0] all_outputs();
        return {42'd0, busy, done, error, aborted, bytes_copied, checksum,
                flash_read_req, flash_read_address, sram_write_req,
                sram_write_address, sram_write_data};
    endfunction

    initial begin
        logic [19:0] rs;
        logic [17:0] rd;
        logic [17:0] rn;
        int          ra;
        int          cyc;

        reset = 1'b1;
        start = 1'b0;
        src_addr = 20'd0;
        dst_addr = 18'd0;
        length = 18'd0;
        #5;
        checkOutput("reset_outputs", all_outputs(), 128'd0);
        repeat (2) @(negedge CLK_40);
        reset = 1'b0;

        // Known data copy.
        flash_over[32'h100] = 8'h01;
        flash_over[32'h101] = 8'h02;
        flash_over[32'h102] = 8'h03;
        flash_over[32'h103] = 8'h04;
        runAndCheck(20'h00100, 18'h00200, 18'd4, 0, 1'b0);
        checkOutput("checksum_known", checksum, 16'h000A);

        // Address wrap on both sides.
        runAndCheck(20'hFFFFE, 18'h3FFFF, 18'd3, 0, 1'b0);

        // Abort during the third write.
        runAndCheck(20'h02000, 18'h01000, 18'd10, 3, 1'b0);

        // Start pulse while busy must be ignored.
        runAndCheck(20'h04444, 18'h02222, 18'd6, 0, 1'b1);

        // Randomized runs.
        for (int k = 0; k < 10; k++) begin
            rs = 20'($urandom);
            if ($urandom_range(0, 3) == 0) rs = 20'hFFFFF - 20'($urandom_range(0, 4));
            rd = 18'($urandom);
            if ($urandom_range(0, 3) == 0) rd = 18'h3FFFF - 18'($urandom_range(0, 4));
            rn = 18'($urandom_range(1, 12));
            ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(rn))) : 0;
            runAndCheck(rs, rd, rn, ra, 1'b0);
        end

        // Flash never acknowledges: timeout error.
        hang_flash = 1'b1;
        abort_at = 0;
        rd_q.delete();
        wr_addr_q.delete();
        @(negedge CLK_40);
        src_addr = 20'h00500;
        dst_addr = 18'h00600;
        length = 18'd5;
        start = 1'b1;
        @(negedge CLK_40);
        start = 1'b0;
        cyc = 1;
        while (!error && cyc < 40) begin
            @(negedge CLK_40);
            cyc++;
        end
        checkOutput("timeout_error", error, 1);
        checkOutput("timeout_cycles", cyc, TIMEOUT + 1);
        checkOutput("timeout_req_low", {flash_read_req, sram_write_req}, 2'b00);
        @(negedge CLK_40);
        checkOutput("timeout_done", done, 1);
        checkOutput("timeout_busy", busy, 0);
        checkOutput("timeout_bytes", bytes_copied, 0);
        hang_flash = 1'b0;

        // Zero length: flags cleared, done pulse, no requests.
        applyStimulus(20'h00700, 18'h00800, 18'd0, 0, 1'b0);
        checkOutput("len0_error_cleared", error, 0);
        checkOutput("len0_reads", rd_q.size(), 0);
        checkOutput("len0_writes", wr_addr_q.size(), 0);

        // Asynchronous reset while waiting for flash read completion.
        rd_q.delete();
        abort_at = 0;
        @(negedge CLK_40);
        src_addr = 20'h0ABCD;
        dst_addr = 18'h01234;
        length = 18'd8;
        start = 1'b1;
        @(negedge CLK_40);
        start = 1'b0;
        cyc = 0;
        while (!(flash_read_req && !flash_read_idle) && cyc < 100) begin
            @(negedge CLK_40);
            cyc++;
        end
        checkOutput("reach_fr_done", cyc < 100, 1);
        @(posedge CLK_40);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_run", all_outputs(), 128'd0);
        repeat (2) @(negedge CLK_40);
        reset = 1'b0;
        repeat (8) @(negedge CLK_40);
        checkOutput("no_done_after_reset", done, 0);

        // Recovery run after reset.
        runAndCheck(20'h00010, 18'h00020, 18'd5, 0, 1'b0);

        checkOutput("req_exclusive", both_req_cnt, 0);

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
